kick_sprite_fetch: RTL

- Upstream stage of the fighter palette lookup.
- Turns the VGA scan position plus fighter position/state into a 4-bit palette index per pixel.
- Sequences a 4-pose kick animation on frame boundaries, generates the sprite ROM address, and mirrors the sprite for facing direction.
- Flags transparent pixels so the colour mapper can show background.

---
 rtl/kick_sprite_fetch.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/kick_sprite_fetch.sv
// Kick animation sequencer and sprite ROM fetch for the fighter palette path.
// Optional macro KICK_CHAIN_EN lets a kick in RECOVER chain straight into WINDUP.
module kick_sprite_fetch #(
  parameter int SPR_W           = 64,
  parameter int SPR_H           = 96,
  parameter int FRAMES_PER_POSE = 6,
  parameter int ADDR_W          = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              kick_req,
  input  logic              facing_left,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  output logic              sprite_on,
  output logic              kick_busy,
  output logic [1:0]        pose
);

  localparam int CW = $clog2(FRAMES_PER_POSE + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_POSE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDUP  = 2'd1,
    EXTEND  = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            busy_q;
  logic            can_req;
  logic            pend_now;
  logic            last;

`ifdef KICK_CHAIN_EN
  assign can_req = (state_q == IDLE) || (state_q == RECOVER);
`else
  assign can_req = (state_q == IDLE);
`endif

  // a request arriving with frame_start still counts for that frame
  assign pend_now = pend_q | (kick_req & can_req);
  assign last     = (cnt_q == LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_now;
    if (frame_start) begin
      unique case (state_q)
        IDLE: begin
          if (pend_now) begin
            state_d = WINDUP;
            pend_d  = 1'b0;
            cnt_d   = '0;
          end
        end
        WINDUP, EXTEND: begin
          if (last) begin
            state_d = state_e'(state_q + 2'd1);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RECOVER: begin
          if (last) begin
            cnt_d = '0;
            if (pend_now) begin
              state_d = WINDUP;
              pend_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [10:0]       dx, dy, col;
  logic [10:0]       x11, y11, sx11, sy11;
  logic              in_box;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inb1_q, inb2_q;

  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign sx11 = {1'b0, sprite_x};
  assign sy11 = {1'b0, sprite_y};
  assign dx   = x11 - sx11;
  assign dy   = y11 - sy11;

  // 11-bit bounds so a box near 1023 never wraps to column 0
  assign in_box = (x11 >= sx11) && (x11 < sx11 + 11'(SPR_W)) &&
                  (y11 >= sy11) && (y11 < sy11 + 11'(SPR_H));

  assign col = facing_left ? (11'(SPR_W - 1) - dx) : dx;

  assign addr_full = 32'(state_q) * 32'(SPR_W * SPR_H) +
                     32'(dy) * 32'(SPR_W) + 32'(col);

  assign addr_d = in_box ? ADDR_W'(addr_full) : addr_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q <= '0;
      inb1_q <= 1'b0;
      inb2_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      inb1_q <= in_box;
      inb2_q <= inb1_q;
    end
  end

  always_comb begin
    rom_addr  = addr_q;
    kick_busy = busy_q;
    pose      = state_q;
    pal_index = inb2_q ? rom_data : 4'd0;
    sprite_on = inb2_q && (rom_data != 4'd0);
  end

endmodule
